// File: rtl/hls_deadlock_report_ctrl.sv
// Purpose: confirms persistent per-dataflow deadlock monitor block flags and reports each one once, round-robin.
// Latency: pending is set CONFIRM_CYCLES cycles after the first sampled high; report_valid follows one cycle later.
// Backpressure: report_valid/idx/ts are held stable until report_ready; no new report is started while one is waiting.
// Optional: define HLS_DEADLOCK_TIMESTAMP_EN to build the free-running cycle counter that stamps report_ts.
module hls_deadlock_report_ctrl #(
    parameter int NUM_MON        = 4,
    parameter int CONFIRM_CYCLES = 16,
    localparam int IDX_W         = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [31:0]        report_ts,
    output logic [NUM_MON-1:0] deadlock_sticky
);

    localparam logic [15:0] CONFIRM_M1 = 16'(CONFIRM_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [15:0]        cnt [NUM_MON];
    logic [NUM_MON-1:0] armed;
    logic [NUM_MON-1:0] pending;
    logic [NUM_MON-1:0] confirm;
    logic [NUM_MON-1:0] pending_nxt;
    logic [NUM_MON-1:0] sticky_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   pos_idx;
    logic               grant_hit;
    logic               handshake;

    assign handshake = report_valid & report_ready;

    // A monitor confirms on the edge its counter reaches CONFIRM_CYCLES, once per high episode.
    always_comb begin
        for (int i = 0; i < NUM_MON; i++) begin
            confirm[i] = block_in[i] && armed[i] && (cnt[i] == CONFIRM_M1);
        end
    end

    // Persistence counters saturate at 16 bits; armed re-arms only after a sampled low.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MON; i++) begin
                cnt[i] <= '0;
            end
            armed <= '1;
        end else begin
            for (int i = 0; i < NUM_MON; i++) begin
                if (block_in[i]) begin
                    if (cnt[i] != 16'hFFFF) begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                    if (confirm[i]) begin
                        armed[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]   <= '0;
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first pending bit at or above rr_ptr, wrapping past NUM_MON-1.
    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        pos_idx   = '0;
        for (int k = 0; k < NUM_MON; k++) begin
            pos_idx = IDX_W'((int'(rr_ptr) + k) % NUM_MON);
            if (!grant_hit && pending[pos_idx]) begin
                grant_hit = 1'b1;
                grant_idx = pos_idx;
            end
        end
    end

    // Next pending/sticky: clear wipes both, the handshake still lands its sticky bit, confirmations win over clear.
    always_comb begin
        pending_nxt = clear ? '0 : pending;
        sticky_nxt  = clear ? '0 : deadlock_sticky;
        if (handshake) begin
            pending_nxt[report_idx] = 1'b0;
            sticky_nxt[report_idx]  = 1'b1;
        end
        pending_nxt = pending_nxt | confirm;
    end

    // Report FSM with registered valid/idx; the in-flight report is never altered by clear or block_in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            report_valid    <= 1'b0;
            report_idx      <= '0;
            pending         <= '0;
            deadlock_sticky <= '0;
            rr_ptr          <= '0;
        end else begin
            pending         <= pending_nxt;
            deadlock_sticky <= sticky_nxt;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state        <= SEND;
                        report_valid <= 1'b1;
                        report_idx   <= grant_idx;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        state        <= IDLE;
                        report_valid <= 1'b0;
                        rr_ptr       <= (report_idx == IDX_W'(NUM_MON - 1)) ? '0 : report_idx + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    report_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HLS_DEADLOCK_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter; the report stamp is taken on the IDLE->SEND edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt    <= '0;
            report_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == IDLE && |pending) begin
                report_ts <= ts_cnt;
            end
        end
    end
`else
    assign report_ts = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
module tb_hls_deadlock_report_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  block_in;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [1:0]  report_idx;
    logic [31:0] report_ts;
    logic [3:0]  deadlock_sticky;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

`ifdef HLS_DEADLOCK_TIMESTAMP_EN
    localparam logic [31:0] TS_SINGLE = 32'd18;
    localparam bit          TS_EN     = 1'b1;
`else
    localparam logic [31:0] TS_SINGLE = 32'd0;
    localparam bit          TS_EN     = 1'b0;
`endif

    hls_deadlock_report_ctrl #(.NUM_MON(4), .CONFIRM_CYCLES(8)) dut (
        .clock(clock),
        .reset(reset),
        .block_in(block_in),
        .clear(clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_idx(report_idx),
        .report_ts(report_ts),
        .deadlock_sticky(deadlock_sticky)
    );

    always #5 clock = ~clock;

    // Reference cycle count since reset, used to predict timestamps.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        block_in = 4'b0000;
        clear = 1'b0;
        report_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", report_valid); end
        checks++; if (report_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", report_idx); end
        checks++; if (report_ts !== 32'd0) begin errors++; $display("FAIL reset_ts got %0d exp 0", report_ts); end
        checks++; if (deadlock_sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky got %b exp 0000", deadlock_sticky); end
    endtask

    task automatic test_single();
        do_reset();
        report_ready = 1'b1;
        repeat (10) next_cycle();
        block_in = 4'b0100;
        repeat (8) next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", report_valid); end
        next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", report_valid); end
        checks++; if (report_idx !== 2'd2) begin errors++; $display("FAIL single_idx got %0d exp 2", report_idx); end
        checks++; if (report_ts !== TS_SINGLE) begin errors++; $display("FAIL single_ts got %0d exp %0d", report_ts, TS_SINGLE); end
        next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0b exp 0", report_valid); end
        checks++; if (deadlock_sticky !== 4'b0100) begin errors++; $display("FAIL single_sticky got %b exp 0100", deadlock_sticky); end
        block_in = 4'b0000;
        next_cycle();
    endtask

    task automatic test_no_confirm();
        int seen;
        seen = 0;
        for (int t = 0; t < 22; t++) begin
            block_in = {1'b0, ((t < 7) || (t >= 8 && t < 15)), 2'b00};
            @(negedge clock);
            if (report_valid) seen++;
            next_cycle();
        end
        block_in = 4'b0000;
        checks++; if (seen !== 0) begin errors++; $display("FAIL no_confirm_valid_cycles got %0d exp 0", seen); end
    endtask

    task automatic test_round_robin();
        bit       exp_v [8];
        logic [1:0] exp_i [8];
        exp_v = '{1, 0, 1, 0, 1, 0, 0, 0};
        exp_i = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
        do_reset();
        report_ready = 1'b1;
        block_in = 4'b1011;
        repeat (8) next_cycle();
        for (int t = 0; t < 8; t++) begin
            next_cycle();
            @(negedge clock);
            checks++; if (report_valid !== exp_v[t]) begin errors++; $display("FAIL rr_valid[%0d] got %0b exp %0b", t, report_valid, exp_v[t]); end
            if (exp_v[t]) begin
                checks++; if (report_idx !== exp_i[t]) begin errors++; $display("FAIL rr_idx[%0d] got %0d exp %0d", t, report_idx, exp_i[t]); end
            end
        end
        checks++; if (deadlock_sticky !== 4'b1011) begin errors++; $display("FAIL rr_sticky got %b exp 1011", deadlock_sticky); end
        block_in = 4'b0000;
        next_cycle();
    endtask

    task automatic test_stall();
        logic [31:0] exp_ts;
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clock);
        checks++; if (deadlock_sticky !== 4'b0000) begin errors++; $display("FAIL clear_sticky got %b exp 0000", deadlock_sticky); end
        report_ready = 1'b0;
        block_in = 4'b0010;
        repeat (9) next_cycle();
        exp_ts = TS_EN ? 32'(cyc - 1) : 32'd0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 1", s, report_valid); end
            checks++; if (report_idx !== 2'd1) begin errors++; $display("FAIL stall_idx[%0d] got %0d exp 1", s, report_idx); end
            checks++; if (report_ts !== exp_ts) begin errors++; $display("FAIL stall_ts[%0d] got %0d exp %0d", s, report_ts, exp_ts); end
            if (s == 1) block_in = 4'b0000;
            if (s == 4) report_ready = 1'b1;
            next_cycle();
        end
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL stall_accept got %0b exp 0", report_valid); end
        checks++; if (deadlock_sticky !== 4'b0010) begin errors++; $display("FAIL stall_sticky got %b exp 0010", deadlock_sticky); end
    endtask

    task automatic test_hold_high();
        int n;
        logic [1:0] idx;
        n = 0;
        idx = 2'd0;
        block_in = 4'b0010;
        for (int t = 0; t < 30; t++) begin
            next_cycle();
            @(negedge clock);
            if (report_valid) begin n++; idx = report_idx; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL hold_reports got %0d exp 1", n); end
        block_in = 4'b0000;
        next_cycle();
        block_in = 4'b0010;
        n = 0;
        idx = 2'd0;
        for (int t = 0; t < 12; t++) begin
            next_cycle();
            @(negedge clock);
            if (report_valid) begin n++; idx = report_idx; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL rearm_reports got %0d exp 1", n); end
        checks++; if (idx !== 2'd1) begin errors++; $display("FAIL rearm_idx got %0d exp 1", idx); end
        block_in = 4'b0000;
        next_cycle();
    endtask

    task automatic test_clear_during_send();
        int n;
        do_reset();
        block_in = 4'b1001;
        repeat (9) next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b1 || report_idx !== 2'd0) begin errors++; $display("FAIL clr_first got v=%0b idx=%0d exp v=1 idx=0", report_valid, report_idx); end
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clock);
        checks++; if (report_valid !== 1'b1 || report_idx !== 2'd0) begin errors++; $display("FAIL clr_held got v=%0b idx=%0d exp v=1 idx=0", report_valid, report_idx); end
        next_cycle();
        report_ready = 1'b1;
        next_cycle();
        @(negedge clock);
        checks++; if (deadlock_sticky !== 4'b0001) begin errors++; $display("FAIL clr_sticky got %b exp 0001", deadlock_sticky); end
        n = 0;
        for (int t = 0; t < 10; t++) begin
            next_cycle();
            @(negedge clock);
            if (report_valid) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL clr_dropped_reports got %0d exp 0", n); end
        block_in = 4'b0000;
        next_cycle();
    endtask

    task automatic test_confirm_wins();
        block_in = 4'b0100;
        repeat (7) next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clock);
        checks++; if (deadlock_sticky !== 4'b0000) begin errors++; $display("FAIL cw_sticky_cleared got %b exp 0000", deadlock_sticky); end
        next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b1 || report_idx !== 2'd2) begin errors++; $display("FAIL cw_report got v=%0b idx=%0d exp v=1 idx=2", report_valid, report_idx); end
        next_cycle();
        @(negedge clock);
        checks++; if (deadlock_sticky !== 4'b0100) begin errors++; $display("FAIL cw_sticky got %b exp 0100", deadlock_sticky); end
        block_in = 4'b0000;
        next_cycle();
    endtask

    task automatic test_reset_mid_send();
        report_ready = 1'b0;
        block_in = 4'b0001;
        repeat (9) next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL rms_valid got %0b exp 1", report_valid); end
        reset = 1'b1;
        report_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
        block_in = 4'b0000;
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL rms_valid_after got %0b exp 0", report_valid); end
        checks++; if (deadlock_sticky !== 4'b0000) begin errors++; $display("FAIL rms_sticky got %b exp 0000", deadlock_sticky); end
        checks++; if (report_ts !== 32'd0) begin errors++; $display("FAIL rms_ts got %0d exp 0", report_ts); end
        next_cycle();
        @(negedge clock);
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL rms_no_resend got %0b exp 0", report_valid); end
    endtask

    initial begin
        reset = 1'b1;
        block_in = 4'b0000;
        clear = 1'b0;
        report_ready = 1'b0;
        test_reset();
        test_single();
        test_no_confirm();
        test_round_robin();
        test_stall();
        test_hold_high();
        test_clear_during_send();
        test_confirm_wins();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_report_ctrl.md
HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: hls_deadlock_report_ctrl

Interface
REQ-001 SHALL have parameter NUM_MON, default 4: number of per-dataflow deadlock monitor `block` flags collected.
REQ-002 SHALL have parameter CONFIRM_CYCLES, default 16, legal range 1..65535: consecutive high cycles required to confirm a deadlock.
REQ-003 SHALL have port clock  input  1: clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port block_in  input  NUM_MON: per-monitor block flags; bit i comes from monitor i.
REQ-006 SHALL have port clear  input  1: one-cycle pulse; clears sticky status and pending requests.
REQ-007 SHALL have port report_valid  output  1: a deadlock report is presented.
REQ-008 SHALL have port report_ready  input  1: the consumer accepts the report.
REQ-009 SHALL have port report_idx  output  clog2(NUM_MON), minimum 1: index of the reported monitor.
REQ-010 SHALL have port report_ts  output  32: cycle timestamp of the report (see Configuration).
REQ-011 SHALL have port deadlock_sticky  output  NUM_MON: bit i is set once monitor i has been reported, and stays set until clear.

Function
REQ-012 SHALL keep a 16-bit saturating persistence counter per monitor.
- Counter increments in each cycle that block_in[i]=1.
- Counter returns to 0 in any cycle that block_in[i]=0.
REQ-013 SHALL set pending[i] at the clock edge where counter i reaches CONFIRM_CYCLES.
- Latency: pending[i] is visible CONFIRM_CYCLES cycles after the first sampled high.
- pending[i] sets only once per episode. An armed[i] flag clears on confirmation and re-arms only after block_in[i] has been sampled 0.
REQ-014 SHALL run the FSM states IDLE and SEND.
- IDLE->SEND when any pending bit is set.
- SEND->IDLE on report_valid & report_ready.
REQ-015 On entry to SEND, SHALL select the granted index round-robin: the first pending bit at or after rr_ptr, searching upward with wrap.
- report_valid and report_idx are registered and asserted in the cycle after the IDLE->SEND edge.
REQ-016 SHALL hold report_valid, report_idx and report_ts stable while report_valid=1 and report_ready=0.
REQ-017 On handshake, SHALL:
- clear pending[granted];
- set deadlock_sticky[granted];
- set rr_ptr to granted+1, wrapping NUM_MON-1 to 0;
- deassert report_valid in the next cycle.
Minimum spacing between two reports is 2 cycles.
REQ-018 If clear and a confirmation occur in the same cycle for the same bit, SHALL make the confirmation win, leaving pending[i]=1.
REQ-019 If clear arrives during SEND, SHALL complete the in-flight report unchanged.
- The handshake still sets the sticky bit.
- All other pending bits clear.
REQ-020 If block_in[i] drops while pending[i]=1 or while i is being reported, SHALL still report it; pending is not withdrawn.
REQ-021 SHALL keep counters, armed flags and the FSM unaffected by clear.

Reset
REQ-022 When reset=1 at a clock edge, SHALL drive the following:
- FSM=IDLE, report_valid=0, report_idx=0, report_ts=0;
- deadlock_sticky=0, pending=0, rr_ptr=0;
- all counters=0, all armed=1, timestamp counter=0.
REQ-023 Reset mid-SEND SHALL drop the report without a handshake and leave no sticky bit set.

Configuration
REQ-024 Macro HLS_DEADLOCK_TIMESTAMP_EN defined:
- A 32-bit free-running cycle counter runs from reset, incrementing every cycle and wrapping 0xFFFFFFFF->0.
- report_ts captures the counter value on the IDLE->SEND edge.
REQ-025 Macro undefined: the counter is not built and report_ts is constant 0. All other behaviour is identical.

Verification (NUM_MON=4, CONFIRM_CYCLES=8)
REQ-026 block_in[2] high from cycle 10, report_ready=1 -> pending[2] at cycle 18, report_valid=1 with report_idx=2 at cycle 19, deadlock_sticky=4'b0100 from cycle 20.
REQ-027 block_in[2] high for 7 cycles, low 1 cycle, high for 7 cycles -> no report_valid ever.
REQ-028 block_in=4'b1011 high together, report_ready=1, rr_ptr=0 -> idx order 0,1,3, each report_valid 1 cycle with 1 idle cycle between, sticky=4'b1011.
REQ-029 report_ready=0 for 5 cycles during SEND, with block_in[1] dropping meanwhile -> report_valid, report_idx and report_ts stable all 5 cycles; accepted on first ready; block_in[1] held high afterward produces no second report until it goes low then high for 8 cycles.
REQ-030 clear pulse during a stalled report of idx 0 while pending[3]=1 -> report of 0 completes with sticky[0]=1; pending[3] dropped, so no report of 3.
REQ-031 With HLS_DEADLOCK_TIMESTAMP_EN, confirm at cycle 18 after reset at cycle 0 -> report_ts=18; without the macro, report_ts=0.
